result_pattern_detector: RTL and testbench

RESULT_PATTERN_DETECTOR -- requirements
Module: result_pattern_detector

---
 rtl/result_pattern_detector.sv | 128 ++++++++++++
 tb/tb_result_pattern_detector.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_pattern_detector.sv
// Watches the ALU zero-flag stream for a programmable Z pattern. Each match gives a
// one-cycle pulse, records the matching X value and bumps a saturating counter.
module result_pattern_detector #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_LEN     = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_x,
  input  logic                   in_z,
  input  logic                   cfg_load,
  input  logic [MAX_LEN-1:0]     cfg_pattern,
  input  logic [3:0]             cfg_length,
  output logic                   det_pulse,
  output logic [DATA_WIDTH-1:0]  match_x,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic                   count_sat,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

  state_e                 state_q, state_d;
  logic [MAX_LEN-1:0]     pattern_q, pattern_d;
  logic [3:0]             len_q, len_d;
  logic [MAX_LEN-1:0]     hist_q, hist_d;
  logic [3:0]             fill_q, fill_d;
  logic                   det_q, det_d;
  logic [DATA_WIDTH-1:0]  match_x_q, match_x_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   sat_q, sat_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [3:0]         cfg_len_clamped;
  logic               accept;
  logic               complete;
  logic               is_match;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (4'(i) < len_q);
    end
  end

  assign hist_shift      = {hist_q[MAX_LEN-2:0], in_z};
  assign cfg_len_clamped = (cfg_length > MAX_LEN_L) ? MAX_LEN_L : cfg_length;
  assign accept          = in_valid && !cfg_load && (state_q != ST_IDLE);
  // A sample is judged only once the history holds len_q valid entries.
  assign complete        = accept && ((state_q == ST_ARMED) ||
                           ((state_q == ST_FILL) && (fill_q == len_q - 4'd1)));
  assign is_match        = complete && (((hist_shift ^ pattern_q) & len_mask) == '0);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    det_d     = 1'b0;
    match_x_d = match_x_q;
    count_d   = count_q;
    sat_d     = sat_q;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len_clamped;
      hist_d    = '0;
      fill_d    = '0;
      match_x_d = '0;
      count_d   = '0;
      sat_d     = 1'b0;
      state_d   = (cfg_len_clamped == 4'd0) ? ST_IDLE : ST_FILL;
    end else if (accept) begin
      hist_d = hist_shift;
      if (state_q == ST_FILL) begin
        fill_d = fill_q + 4'd1;
        if (complete) state_d = ST_ARMED;
      end
      if (is_match) begin
        det_d     = 1'b1;
        match_x_d = in_x;
        if (count_q == '1) sat_d = 1'b1;
        else               count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      det_q     <= 1'b0;
      match_x_q <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
      match_x_q <= match_x_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
    end
  end

  assign det_pulse   = det_q;
  assign match_x     = match_x_q;
  assign match_count = count_q;
  assign count_sat   = sat_q;
  assign state       = state_q;

endmodule

// File: tb/tb_result_pattern_detector.sv
// Scoreboard bench: a queue-based Z history model predicts every cycle's outputs for
// two detector instances (16-bit and 2-bit match counters) driven by shared stimulus.
module tb_result_pattern_detector;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_x;
  logic        in_z;
  logic        cfg_load;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_length;

  logic        det_a, det_b;
  logic [31:0] mx_a, mx_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic        sat_a, sat_b;
  logic [1:0]  st_a, st_b;

  always #5 clk = ~clk;

  result_pattern_detector #(.DATA_WIDTH(32), .MAX_LEN(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_x(in_x), .in_z(in_z),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_length(cfg_length),
    .det_pulse(det_a), .match_x(mx_a), .match_count(cnt_a), .count_sat(sat_a),
    .state(st_a));

  result_pattern_detector #(.DATA_WIDTH(32), .MAX_LEN(8), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_x(in_x), .in_z(in_z),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_length(cfg_length),
    .det_pulse(det_b), .match_x(mx_b), .match_count(cnt_b), .count_sat(sat_b),
    .state(st_b));

  typedef struct {
    logic        det;
    logic [31:0] x;
    int          c16;
    logic        s16;
    int          c2;
    logic        s2;
    logic [1:0]  st;
  } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: configuration plus the list of accepted Z samples.
  int         m_len = 0;
  logic [7:0] m_pat = '0;
  bit         m_hist[$];
  int         m_n = 0;
  logic       m_det = 0;
  logic [31:0] m_x = '0;
  int         m_c16 = 0, m_c2 = 0;
  logic       m_s16 = 0, m_s2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model(input logic rn, input logic cl, input logic [7:0] cp,
                                input logic [3:0] clen, input logic v,
                                input logic [31:0] x, input logic z);
    bit ok;
    if (!rn) begin
      m_len = 0; m_pat = '0; m_hist.delete(); m_n = 0; m_det = 0; m_x = '0;
      m_c16 = 0; m_c2 = 0; m_s16 = 0; m_s2 = 0;
    end else if (cl) begin
      m_len = (clen > 8) ? 8 : int'(clen);
      m_pat = cp; m_hist.delete(); m_n = 0; m_det = 0; m_x = '0;
      m_c16 = 0; m_c2 = 0; m_s16 = 0; m_s2 = 0;
    end else begin
      m_det = 0;
      if (v && m_len > 0) begin
        m_hist.push_back(z);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        m_n++;
        if (m_n >= m_len) begin
          ok = 1;
          for (int i = 0; i < m_len; i++)
            if (m_hist[m_hist.size() - 1 - i] != m_pat[i]) ok = 0;
          if (ok) begin
            m_det = 1; m_x = x;
            if (m_c16 == 65535) m_s16 = 1; else m_c16++;
            if (m_c2 == 3) m_s2 = 1; else m_c2++;
          end
        end
      end
    end
  endfunction

  function automatic logic [1:0] m_state();
    if (m_len == 0) return 2'd0;
    return (m_n >= m_len) ? 2'd2 : 2'd1;
  endfunction

  task automatic step(input logic rn, input logic cl, input logic [7:0] cp,
                      input logic [3:0] clen, input logic v,
                      input logic [31:0] x, input logic z);
    exp_t e;
    @(negedge clk);
    resetn = rn; cfg_load = cl; cfg_pattern = cp; cfg_length = clen;
    in_valid = v; in_x = x; in_z = z;
    model(rn, cl, cp, clen, v, x, z);
    e.det = m_det; e.x = m_x; e.c16 = m_c16; e.s16 = m_s16;
    e.c2 = m_c2; e.s2 = m_s2; e.st = m_state();
    sbq.push_back(e);
  endtask

  task automatic sample(input logic z, input logic [31:0] x);
    step(1, 0, 8'h00, 4'd0, 1, x, z);
  endtask

  task automatic idle();
    step(1, 0, 8'h00, 4'd0, 0, 32'h0, 0);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l);
    step(1, 1, p, l, 0, 32'h0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("det_pulse",   {31'b0, det_a}, {31'b0, e.det});
        chk("match_x",     mx_a, e.x);
        chk("match_count", {16'b0, cnt_a}, 32'(e.c16));
        chk("count_sat",   {31'b0, sat_a}, {31'b0, e.s16});
        chk("state",       {30'b0, st_a}, {30'b0, e.st});
        chk("det_pulse_c2",   {31'b0, det_b}, {31'b0, e.det});
        chk("match_count_c2", {30'b0, cnt_b}, 32'(e.c2));
        chk("count_sat_c2",   {31'b0, sat_b}, {31'b0, e.s2});
      end
    end
  end

  initial begin : stim
    int r;
    resetn = 0; cfg_load = 0; cfg_pattern = '0; cfg_length = '0;
    in_valid = 0; in_x = '0; in_z = 0;

    step(0, 0, 8'h00, 4'd0, 0, 32'h0, 0);
    step(0, 0, 8'h00, 4'd0, 1, 32'h1, 1);
    settle();
    chk("reset_state", {30'b0, st_a}, 32'd0);
    chk("reset_count", {16'b0, cnt_a}, 32'd0);
    idle();
    sample(1, 32'h7);
    sample(1, 32'h7);
    settle();
    chk("idle_ignores", {31'b0, det_a}, 32'd0);

    // basic + overlap, pattern 101 over 3 samples
    cfg(8'b0000_0101, 4'd3);
    sample(1, 32'h0);
    sample(0, 32'h5);
    sample(1, 32'h0);
    settle();
    chk("basic_det", {31'b0, det_a}, 32'd1);
    chk("basic_x",   mx_a, 32'h0);
    chk("basic_cnt", {16'b0, cnt_a}, 32'd1);
    sample(0, 32'h9);
    sample(1, 32'hAB);
    settle();
    chk("overlap_det", {31'b0, det_a}, 32'd1);
    chk("overlap_x",   mx_a, 32'hAB);
    chk("overlap_cnt", {16'b0, cnt_a}, 32'd2);
    chk("overlap_st",  {30'b0, st_a}, 32'd2);

    // gaps, then cfg_load colliding with a valid sample
    cfg(8'b0000_0101, 4'd3);
    sample(1, 32'h1);
    sample(0, 32'h2);
    idle(); idle(); idle();
    step(1, 1, 8'b0000_0101, 4'd3, 1, 32'h3, 1);
    settle();
    chk("conflict_det", {31'b0, det_a}, 32'd0);
    chk("conflict_st",  {30'b0, st_a}, 32'd1);
    chk("conflict_cnt", {16'b0, cnt_a}, 32'd0);

    // saturation on the 2-bit counter instance
    cfg(8'h01, 4'd1);
    for (int i = 0; i < 5; i++) sample(1, 32'(i + 16));
    settle();
    chk("sat_det", {31'b0, det_b}, 32'd1);
    chk("sat_cnt", {30'b0, cnt_b}, 32'd3);
    chk("sat_flag", {31'b0, sat_b}, 32'd1);

    // length above MAX_LEN clamps to 8
    cfg(8'hFF, 4'd12);
    for (int i = 0; i < 8; i++) sample(1, 32'h55);
    settle();
    chk("clamp_det", {31'b0, det_a}, 32'd1);

    // reset in the middle of FILL
    cfg(8'b0000_1011, 4'd4);
    sample(1, 32'h1);
    sample(0, 32'h2);
    sample(1, 32'h3);
    step(0, 0, 8'h00, 4'd0, 0, 32'h0, 0);
    settle();
    chk("rst_mid_st",  {30'b0, st_a}, 32'd0);
    chk("rst_mid_x",   mx_a, 32'h0);
    idle();
    sample(1, 32'h4);
    settle();
    chk("rst_mid_nodet", {31'b0, det_a}, 32'd0);
    chk("rst_mid_idle",  {30'b0, st_a}, 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 20000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 5)
        step(0, 0, 8'h00, 4'd0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
      else if (r < 35)
        step(1, 1, 8'($urandom), 4'($urandom_range(0, 10)), $urandom_range(0, 1),
             $urandom, $urandom_range(0, 1));
      else if (r < 250)
        idle();
      else
        sample($urandom_range(0, 1), $urandom);
    end

    for (int i = 0; i < 4 && sbq.size() > 0; i++) settle();
    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
